// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state encoding, direction constants and width helper
package elevator_pkg;
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/elevator_motion_ctrl_floor_scheduler.sv
// floor_scheduler: SCAN direction choice from the pending-floor mask
module floor_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W = 2
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  motor_dir,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  next_dir
);
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      any_above = any_above | (pending[i] & (i > int'(cur_floor)));
      any_below = any_below | (pending[i] & (i < int'(cur_floor)));
    end
    next_dir = (motor_dir == DIR_UP) ? (any_above | ~any_below) : (any_above & ~any_below);
  end
endmodule

// File: rtl/elevator_motion_ctrl.sv
// elevator_motion_ctrl: SCAN-ordered floor controller driving the step-motor enable and direction
module elevator_motion_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W = 2,
  parameter int TICKS_PER_FLOOR = 8_000_000,
  parameter int DOOR_TICKS = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  output logic               req_ready,
  output logic               motor_onoff,
  output logic               motor_dir,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               door_open,
  output logic               busy,
  output logic               arrived
);
  localparam int TW = width_of(TICKS_PER_FLOOR);
  localparam int DW = width_of(DOOR_TICKS + 1);
  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);
  state_t state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, set_mask, clr_mask;
  logic [FLOOR_W-1:0] floor_q, floor_d, next_floor, sched_floor;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] tmr_q, tmr_d;
  logic dir_q, dir_d, arrived_q, arrived_d, motor_q;
  logic any_above, any_below, next_dir, ahead, door_hit;
  // In MOVE the scheduler looks ahead from the floor the car is about to reach
  assign next_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
  assign sched_floor = (state_q == MOVE) ? next_floor : floor_q;
  assign ahead = dir_q ? any_above : any_below;
  assign door_hit = req_valid && (req_floor == floor_q);
  assign set_mask = (req_valid && (int'(req_floor) < NUM_FLOORS) && !(state_q == DOOR && door_hit))
                    ? ONE << req_floor : '0;
  floor_scheduler #(
    .NUM_FLOORS(NUM_FLOORS),
    .FLOOR_W(FLOOR_W)
  ) u_sched (
    .pending(pending_q),
    .cur_floor(sched_floor),
    .motor_dir(dir_q),
    .any_above(any_above),
    .any_below(any_below),
    .next_dir(next_dir)
  );
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    tmr_d = tmr_q;
    arrived_d = 1'b0;
    clr_mask = '0;
    unique case (state_q)
      IDLE: begin
        if (pending_q[floor_q]) begin
          clr_mask = ONE << floor_q;
          arrived_d = 1'b1;
          tmr_d = DW'(DOOR_TICKS);
          state_d = DOOR;
        end else if (|pending_q) begin
          dir_d = next_dir;
          cnt_d = '0;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (cnt_q == TW'(TICKS_PER_FLOOR - 1)) begin
          floor_d = next_floor;
          cnt_d = '0;
          if (pending_q[next_floor]) begin
            clr_mask = ONE << next_floor;
            arrived_d = 1'b1;
            tmr_d = DW'(DOOR_TICKS);
            state_d = DOOR;
          end else if (!ahead) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      DOOR: begin
        if (door_hit) begin
          tmr_d = DW'(DOOR_TICKS);
        end else if (tmr_q == DW'(1)) begin
          tmr_d = '0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A clear always beats a same-cycle capture: the car is at that floor
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pending_q <= '0;
      floor_q <= '0;
      dir_q <= DIR_UP;
      cnt_q <= '0;
      tmr_q <= '0;
      arrived_q <= 1'b0;
      motor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      floor_q <= floor_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      arrived_q <= arrived_d;
      motor_q <= (state_d == MOVE);
    end
  end
  assign req_ready = 1'b1;
  assign motor_onoff = motor_q;
  assign motor_dir = dir_q;
  assign cur_floor = floor_q;
  assign door_open = (state_q == DOOR);
  assign busy = (state_q != IDLE) || (|pending_q);
  assign arrived = arrived_q;
endmodule
